// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU writeback execution stage.
// Opcode 111 is a multiply when ALU_MUL_EN is defined and a NOP otherwise.
package alu_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned ADDR_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        MUL,
        WB
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for opcodes 000-110; opcode 111 yields zero result and carry.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  opcode_t           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit holds carry-out for ADD and borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_wb_unit.sv
// Sequencing execution stage: reads two registers, computes, writes back, updates flags.
// Define ALU_MUL_EN to make opcode 111 an 8-cycle shift-add multiply instead of a NOP.
module alu_wb_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              zero,
    output logic              carry,
    output logic              done
);

    state_t            state_q, state_d;
    opcode_t           op_q;
    logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q, wa_q;
    logic [DATA_W-1:0] a_q, b_q, wdata_q;
    logic              res_carry_q, nop_q, zero_q, carry_q;
    logic [DATA_W-1:0] core_result;
    logic              core_carry;
    logic              accept;
    logic              is_nop;

    assign accept = instr_valid && (state_q == IDLE);

`ifdef ALU_MUL_EN
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]    mul_cnt_q;
    logic [2*DATA_W-1:0] mul_acc_q;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign is_nop = 1'b0;

    // Low half starts as the multiplier and is shifted out as the product shifts in.
    assign mul_sum  = {1'b0, mul_acc_q[2*DATA_W-1:DATA_W]} +
                      (mul_acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, mul_acc_q[DATA_W-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt_q <= '0;
            mul_acc_q <= '0;
        end else if (state_q == EXEC) begin
            mul_cnt_q <= '0;
            mul_acc_q <= {{DATA_W{1'b0}}, b_q};
        end else if (state_q == MUL) begin
            mul_cnt_q <= mul_cnt_q + 1'b1;
            mul_acc_q <= mul_next;
        end
    end
`else
    assign is_nop = (op_q == OP_MUL);
`endif

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .carry  (core_carry)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (instr_valid) state_d = READ;
            READ: state_d = EXEC;
            EXEC: begin
`ifdef ALU_MUL_EN
                state_d = (op_q == OP_MUL) ? MUL : WB;
`else
                state_d = WB;
`endif
            end
`ifdef ALU_MUL_EN
            MUL: if (mul_cnt_q == CNT_LAST) state_d = WB;
`endif
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= OP_ADD;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            wa_q        <= '0;
            wdata_q     <= '0;
            res_carry_q <= 1'b0;
            nop_q       <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= opcode_t'(opcode);
                rs1_q <= rs1;
                rs2_q <= rs2;
                rd_q  <= rd;
            end
            if (state_q == READ) begin
                a_q <= rdata1;
                b_q <= rdata2;
            end
            // wa/wdata only move when a write is about to happen, so they hold otherwise.
            if ((state_q == EXEC) && (state_d == WB)) begin
                nop_q <= is_nop;
                if (!is_nop) begin
                    wa_q        <= rd_q;
                    wdata_q     <= core_result;
                    res_carry_q <= core_carry;
                end
            end
`ifdef ALU_MUL_EN
            if ((state_q == MUL) && (state_d == WB)) begin
                nop_q       <= 1'b0;
                wa_q        <= rd_q;
                wdata_q     <= mul_next[DATA_W-1:0];
                res_carry_q <= |mul_next[2*DATA_W-1:DATA_W];
            end
`endif
            if ((state_q == WB) && !nop_q) begin
                zero_q  <= (wdata_q == '0);
                carry_q <= res_carry_q;
            end
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign ra1         = rs1_q;
    assign ra2         = rs2_q;
    assign wa          = wa_q;
    assign wdata       = wdata_q;
    assign we          = (state_q == WB) && !nop_q;
    assign done        = (state_q == WB);
    assign zero        = zero_q;
    assign carry       = carry_q;

endmodule

// File: doc/alu_wb_unit.md
# alu_wb_unit

Sequencing execution stage directly upstream of the 16×8 register file.
- Accepts one register-register instruction per handshake.
- Drives the file's two read addresses, latches both operands, and computes an 8-bit ALU result.
- Writes the result back through the file's single write port.
- Updates zero/carry status flags.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 4, register address width (16 registers)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  unit can accept an instruction
- opcode  in  3  operation select, see Operation
- rs1  in  ADDR_W  source register A
- rs2  in  ADDR_W  source register B
- rd  in  ADDR_W  destination register
- ra1  out  ADDR_W  register file read address 1
- ra2  out  ADDR_W  register file read address 2
- rdata1  in  DATA_W  register file read data 1 (combinational read)
- rdata2  in  DATA_W  register file read data 2
- wa  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data
- we  out  1  register file write enable
- zero  out  1  last written result == 0
- carry  out  1  carry/borrow/shift-out of last written result
- done  out  1  one-cycle pulse when an instruction retires

## Operation
- **Handshake:** an instruction is accepted on a rising edge with instr_valid && instr_ready. rs1, rs2, rd and opcode are latched at acceptance. instr_ready = (state == IDLE).
- **States:**
  - IDLE → READ on accept.
  - READ → EXEC. During READ, ra1/ra2 carry the latched rs1/rs2, and rdata1/rdata2 are registered as A/B at the end of the cycle.
  - EXEC → WB, or EXEC → MUL for opcode 111 when the macro is enabled. The result and carry are registered at the end of EXEC.
  - WB → IDLE. During WB: we=1, wa=rd, wdata=result, and zero/carry update on that edge.
  - MUL → WB after 8 iterations.
- **Opcodes** (result is truncated to DATA_W):
  - 000 ADD: carry = carry-out.
  - 001 SUB: A−B modulo 256; carry = borrow (A<B).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL: A<<1; carry = A[7].
  - 110 SHR: logical A>>1; carry = A[0].
  - 111 MUL: see Configuration.
- **done** pulses in the cycle the state leaves WB. For a NOP (opcode 111 with the macro disabled), done pulses in the cycle the state would have left WB, with no write.
- **Output values:**
  - ra1/ra2 hold the latched values outside READ.
  - wa/wdata hold their last values when we=0.
  - Flags hold their value between writes.
- **Reset** (any time, asynchronous): state=IDLE, instr_ready=1, we=0, done=0, zero=0, carry=0, and ra1/ra2/wa/wdata = 0. Any in-flight instruction is discarded and never written.
- **RAW hazards:** none are possible, because writeback completes before the next instruction's READ.
- **rd == rs1/rs2:** legal; the register is read before it is written.

## Timing
- Acceptance edge = cycle 0. READ = cycle 1, EXEC = cycle 2, WB = cycle 3 (we high), next accept earliest at the edge ending cycle 4.
- Throughput: 1 instruction per 4 cycles (non-MUL).
- MUL: READ = cycle 1, EXEC = cycle 2, MUL = cycles 3–10, WB = cycle 11.
- instr_valid while busy is ignored; the source must hold the instruction until accepted.

## Configuration
- `ALU_MUL_EN` defined:
  - Opcode 111 is an iterative shift-add multiply over 8 cycles, driven by a 3-bit iteration counter.
  - result = product[7:0]; carry = (product[15:8] != 0).
- `ALU_MUL_EN` undefined:
  - Opcode 111 is a NOP: no write, flags unchanged, done pulses in cycle 3.
  - The MUL state and counter are not synthesized.

## Structure
- Shared package alu_pkg:
  - DATA_W/ADDR_W defaults
  - opcode_t enum (OP_ADD … OP_MUL)
  - state_t enum (IDLE, READ, EXEC, MUL, WB)
- Sub-module alu_core: combinational, takes opcode, A and B, and produces result and carry for opcodes 000–110.
- The multiplier datapath and the FSM stay in alu_wb_unit.

## Test plan
Bench instantiates alu_wb_unit driving the existing 16×8 register file, preloaded via its write port.
- **Reset:** reset asserted → instr_ready=1, we=0, done=0, zero=0, carry=0.
- **ADD with carry:** R1=200, R2=100, ADD rd=3 → cycle 3: we=1, wa=3, wdata=44; then carry=1, zero=0; R3 reads 44.
- **SUB:**
  - R4=5, R5=5, SUB rd=7 → wdata=0, zero=1, carry=0.
  - R4−R2 (5−100) → wdata=161, carry=1.
- **Back-to-back dependency:** ADD R3=R1+R2, then immediately ADD R6=R3+R3 offered with instr_valid held → second accepted at cycle 4, R6=88, carry=0.
- **Reset mid-operation:** reset asserted during EXEC of ADD rd=9 → R9 unchanged, we never high, instr_ready=1 after release.
- **MUL:**
  - `ALU_MUL_EN`: R1=20, R8=13, MUL rd=10 → we in cycle 11, wdata=4, carry=1.
  - Without the macro: no write, done at cycle 3, flags unchanged.
